// File: rtl/window_stats_tracker_pkg.sv
// Shared definitions for the window statistics stage: FSM state encoding and
// default widths matching the upstream 8-bit magnitude comparator.
package window_stats_tracker_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    localparam int WIDTH_DEF = 8;
    localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/window_stats_tracker_cmp8.sv
// Unsigned magnitude comparator (the Comparator8 block) giving one-hot GT/LT/EQ
// flags for a against b.
module window_stats_tracker_cmp8
    import window_stats_tracker_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             gt,
    output logic             lt,
    output logic             eq
);

    assign gt = (a > b);
    assign lt = (a < b);
    assign eq = (a == b);

endmodule

// File: rtl/window_stats_tracker.sv
// Groups an unsigned sample stream into windows of WINDOW samples and publishes
// max, min and rise/fall/same trend counts per window over valid/ready.
module window_stats_tracker
    import window_stats_tracker_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int WINDOW = 8,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_max,
    output logic [WIDTH-1:0] res_min,
    output logic [CNT_W-1:0] res_rise,
    output logic [CNT_W-1:0] res_fall,
    output logic [CNT_W-1:0] res_same
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] max_q, min_q, prev_q;
    logic [CNT_W-1:0] cnt, rise, fall, same;

    logic gt_prev, lt_prev, eq_prev;
    logic gt_max, lt_max, eq_max;
    logic gt_min, lt_min, eq_min;
    logic unused_flags;

    logic             accept;
    logic [WIDTH-1:0] next_max, next_min;
    logic [CNT_W-1:0] next_rise, next_fall, next_same;

    window_stats_tracker_cmp8 #(.WIDTH(WIDTH)) u_cmp_prev (
        .a(in_data), .b(prev_q), .gt(gt_prev), .lt(lt_prev), .eq(eq_prev)
    );
    window_stats_tracker_cmp8 #(.WIDTH(WIDTH)) u_cmp_max (
        .a(in_data), .b(max_q), .gt(gt_max), .lt(lt_max), .eq(eq_max)
    );
    window_stats_tracker_cmp8 #(.WIDTH(WIDTH)) u_cmp_min (
        .a(in_data), .b(min_q), .gt(gt_min), .lt(lt_min), .eq(eq_min)
    );

    // Only GT against max and LT against min matter; ties keep the extreme.
    assign unused_flags = ^{lt_max, eq_max, gt_min, eq_min};

    // in_ready is registered, so a clear in the same cycle must drop the sample here.
    assign accept    = in_valid & in_ready & ~clear;
    assign next_max  = gt_max ? in_data : max_q;
    assign next_min  = lt_min ? in_data : min_q;
    assign next_rise = rise + CNT_W'(gt_prev);
    assign next_fall = fall + CNT_W'(lt_prev);
    assign next_same = same + CNT_W'(eq_prev);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            res_valid <= 1'b0;
            max_q     <= '0;
            min_q     <= '0;
            prev_q    <= '0;
            cnt       <= '0;
            rise      <= '0;
            fall      <= '0;
            same      <= '0;
            res_max   <= '0;
            res_min   <= '0;
            res_rise  <= '0;
            res_fall  <= '0;
            res_same  <= '0;
        end else if (clear) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            res_valid <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        state  <= ACCUM;
                        max_q  <= in_data;
                        min_q  <= in_data;
                        prev_q <= in_data;
                        cnt    <= CNT_W'(1);
                        rise   <= '0;
                        fall   <= '0;
                        same   <= '0;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        if (cnt == LAST) begin
                            // Final sample lands directly in the result record.
                            res_max   <= next_max;
                            res_min   <= next_min;
                            res_rise  <= next_rise;
                            res_fall  <= next_fall;
                            res_same  <= next_same;
                            res_valid <= 1'b1;
                            in_ready  <= 1'b0;
                            cnt       <= '0;
                            state     <= HOLD;
                        end else begin
                            max_q  <= next_max;
                            min_q  <= next_min;
                            prev_q <= in_data;
                            rise   <= next_rise;
                            fall   <= next_fall;
                            same   <= next_same;
                            cnt    <= cnt + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        state     <= IDLE;
                        res_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    res_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule
